// File: rtl/bomberman_regs_pkg.sv
// Shared constants, types and the byte-strobe merge helper for the
// bomberman AXI4-Lite register bank.
package bomberman_regs_pkg;

    localparam int NUM_REGS = 4;

    localparam logic [1:0] REG_CTRL = 2'd0;
    localparam logic [1:0] REG_P1   = 2'd1;
    localparam logic [1:0] REG_P2   = 2'd2;
    localparam logic [1:0] REG_MAP  = 2'd3;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    typedef logic [NUM_REGS-1:0][31:0] regfile_t;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bomberman_axi_lite_regs.sv
// AXI4-Lite slave exposing four 32-bit registers to the game logic, with a
// one-cycle write pulse per register on every committed write.
module bomberman_axi_lite_regs
    import bomberman_regs_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output regfile_t                        reg_q,
    output logic [NUM_REGS-1:0]             reg_wr_pulse
);

    wr_state_t   w_state_r, w_next_s;
    rd_state_t   r_state_r, r_next_s;
    logic        awready_r, wready_r, arready_r, bvalid_r, rvalid_r;
    logic [31:0] rdata_r;
    regfile_t    regs_r;
    logic [3:0]  pulse_r;
    logic [1:0]  aw_idx_r;
    logic [31:0] w_data_r;
    logic [3:0]  w_strb_r;
    logic        aw_hs_s, w_hs_s, ar_hs_s;
    logic        commit_s, latch_aw_s, latch_w_s;
    logic [1:0]  c_idx_s;
    logic [31:0] c_data_s;
    logic [3:0]  c_strb_s, c_onehot_s;
    logic        unused_inputs_s;

    assign aw_hs_s = S_AXI_AWVALID & awready_r;
    assign w_hs_s  = S_AXI_WVALID & wready_r;
    assign ar_hs_s = S_AXI_ARVALID & arready_r;

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign reg_q         = regs_r;
    assign reg_wr_pulse  = pulse_r;

    assign unused_inputs_s = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Write FSM next state; also picks the live or latched half of the commit.
    always_comb begin
        w_next_s   = w_state_r;
        commit_s   = 1'b0;
        latch_aw_s = 1'b0;
        latch_w_s  = 1'b0;
        c_idx_s    = S_AXI_AWADDR[3:2];
        c_data_s   = S_AXI_WDATA;
        c_strb_s   = S_AXI_WSTRB;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    commit_s = 1'b1;
                    w_next_s = W_RESP;
                end else if (aw_hs_s) begin
                    latch_aw_s = 1'b1;
                    w_next_s   = W_HAVE_AW;
                end else if (w_hs_s) begin
                    latch_w_s = 1'b1;
                    w_next_s  = W_HAVE_W;
                end else begin
                    w_next_s = W_IDLE;
                end
            end
            W_HAVE_AW: begin
                c_idx_s = aw_idx_r;
                if (w_hs_s) begin
                    commit_s = 1'b1;
                    w_next_s = W_RESP;
                end else begin
                    w_next_s = W_HAVE_AW;
                end
            end
            W_HAVE_W: begin
                c_data_s = w_data_r;
                c_strb_s = w_strb_r;
                if (aw_hs_s) begin
                    commit_s = 1'b1;
                    w_next_s = W_RESP;
                end else begin
                    w_next_s = W_HAVE_W;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_next_s = W_IDLE;
                end else begin
                    w_next_s = W_RESP;
                end
            end
            default: w_next_s = W_IDLE;
        endcase
    end

    // Register index to update-pulse decode.
    always_comb begin
        c_onehot_s = 4'b0000;
        case (c_idx_s)
            REG_CTRL: c_onehot_s = 4'b0001;
            REG_P1:   c_onehot_s = 4'b0010;
            REG_P2:   c_onehot_s = 4'b0100;
            REG_MAP:  c_onehot_s = 4'b1000;
            default:  c_onehot_s = 4'b0000;
        endcase
    end

    // Write FSM state, registered ready/valid flags and the half-transaction latches.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            aw_idx_r  <= 2'd0;
            w_data_r  <= 32'd0;
            w_strb_r  <= 4'd0;
        end else begin
            w_state_r <= w_next_s;
            awready_r <= (w_next_s == W_IDLE) || (w_next_s == W_HAVE_W);
            wready_r  <= (w_next_s == W_IDLE) || (w_next_s == W_HAVE_AW);
            bvalid_r  <= (w_next_s == W_RESP);
            if (latch_aw_s) begin
                aw_idx_r <= S_AXI_AWADDR[3:2];
            end
            if (latch_w_s) begin
                w_data_r <= S_AXI_WDATA;
                w_strb_r <= S_AXI_WSTRB;
            end
        end
    end

    // Register file update and update pulse; the pulse fires even with an all-zero strobe.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_r  <= '0;
            pulse_r <= 4'b0000;
        end else begin
            pulse_r <= commit_s ? c_onehot_s : 4'b0000;
            if (commit_s) begin
                regs_r[c_idx_s] <= apply_strobe(regs_r[c_idx_s], c_data_s, c_strb_s);
            end
        end
    end

    // Read FSM next state.
    always_comb begin
        r_next_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_next_s = R_DATA;
                end else begin
                    r_next_s = R_IDLE;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    r_next_s = R_IDLE;
                end else begin
                    r_next_s = R_DATA;
                end
            end
            default: r_next_s = R_IDLE;
        endcase
    end

    // Read FSM state and read data capture; sampling regs_r here yields the pre-write value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
        end else begin
            r_state_r <= r_next_s;
            arready_r <= (r_next_s == R_IDLE);
            rvalid_r  <= (r_next_s == R_DATA);
            if (ar_hs_s) begin
                rdata_r <= regs_r[S_AXI_ARADDR[3:2]];
            end
        end
    end

endmodule

// File: tb/tb_bomberman_axi_lite_regs.sv
// Self-checking bench: vector table plus hand-written corner sequences, with
// read data, update pulses and write responses checked through scoreboards.
module tb_bomberman_axi_lite_regs;
    import bomberman_regs_pkg::*;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    regfile_t    reg_q;
    logic [3:0]  reg_wr_pulse;

    bomberman_axi_lite_regs dut (
        .ACLK(aclk), .ARESET(areset),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic        is_wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [4];
    logic [31:0] rd_q [$];
    logic [3:0]  pulse_q [$];
    int          exp_b = 0;
    logic [31:0] bp_exp;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge aclk) begin
        if (!areset) begin
            if (rvalid && rready) begin
                checks++;
                if (rd_q.size() == 0) begin
                    failures++;
                    $display("FAIL rd_unexpected actual=rvalid required=no_response");
                end else begin
                    check("rdata", rdata, rd_q.pop_front());
                    check("rresp", rresp, 2'b00);
                end
            end
            if (bvalid && bready) begin
                checks++;
                if (exp_b == 0) begin
                    failures++;
                    $display("FAIL b_unexpected actual=bvalid required=no_response");
                end else begin
                    exp_b--;
                    check("bresp", bresp, 2'b00);
                end
            end
            if (reg_wr_pulse != 4'b0000) begin
                checks++;
                if (pulse_q.size() == 0) begin
                    failures++;
                    $display("FAIL pulse_unexpected actual=%b required=0000", reg_wr_pulse);
                end else begin
                    check("wr_pulse", reg_wr_pulse, pulse_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[addr[3:2]][8*b +: 8] = data[8*b +: 8];
        end
        pulse_q.push_back(4'b0001 << addr[3:2]);
        exp_b++;
    endtask

    task automatic wait_b();
        logic done, hit;
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            hit = bvalid && bready;
            step();
            if (hit) done = 1'b1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL b_timeout actual=no_bvalid required=bvalid");
        end
    endtask

    task automatic wait_r();
        logic done, hit;
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            hit = rvalid && rready;
            step();
            if (hit) done = 1'b1;
        end
        if (!done) begin
            checks++; failures++;
            $display("FAIL r_timeout actual=no_rvalid required=rvalid");
        end
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic aw_done, w_done, aw_hit, w_hit;
        model_write(addr, data, strb);
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        aw_done = 1'b0; w_done = 1'b0;
        for (int n = 0; n < 30 && !(aw_done && w_done); n++) begin
            aw_hit = awvalid && awready;
            w_hit  = wvalid && wready;
            step();
            if (aw_hit) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (w_hit)  begin wvalid = 1'b0;  w_done = 1'b1;  end
        end
        if (!(aw_done && w_done)) begin
            checks++; failures++;
            $display("FAIL wr_handshake_timeout actual=aw%0b_w%0b required=aw1_w1", aw_done, w_done);
            awvalid = 1'b0; wvalid = 1'b0;
        end
        wait_b();
        check("reg_q_after_write", reg_q[addr[3:2]], model[addr[3:2]]);
    endtask

    task automatic do_read(input logic [3:0] addr, input logic [31:0] exp);
        logic done, hit;
        rd_q.push_back(exp);
        araddr = addr; arvalid = 1'b1;
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            hit = arvalid && arready;
            step();
            if (hit) done = 1'b1;
        end
        arvalid = 1'b0;
        if (!done) begin
            checks++; failures++;
            $display("FAIL ar_timeout actual=no_arready required=arready");
        end
        wait_r();
    endtask

    task automatic write_split(input logic [3:0] addr, input logic [31:0] data, input logic aw_first, input int gap);
        model_write(addr, data, 4'hF);
        awaddr = addr; wdata = data; wstrb = 4'hF;
        if (aw_first) begin
            check("split_awready_idle", awready, 1'b1);
            awvalid = 1'b1; step(); awvalid = 1'b0;
            check("have_aw_awready", awready, 1'b0);
            repeat (gap - 1) step();
            check("have_aw_wready", wready, 1'b1);
            wvalid = 1'b1; step(); wvalid = 1'b0;
        end else begin
            check("split_wready_idle", wready, 1'b1);
            wvalid = 1'b1; step(); wvalid = 1'b0;
            check("have_w_wready", wready, 1'b0);
            repeat (gap - 1) step();
            check("have_w_awready", awready, 1'b1);
            awvalid = 1'b1; step(); awvalid = 1'b0;
        end
        wait_b();
        check("reg_q_after_split", reg_q[addr[3:2]], model[addr[3:2]]);
    endtask

    initial begin
        areset = 1'b1;
        awaddr = 4'h0; araddr = 4'h0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; bready = 1'b1; rready = 1'b1;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;

        vecs[0]  = '{1'b1, 4'h0, 32'h0000_0001, 4'hF, 32'h0};
        vecs[1]  = '{1'b1, 4'h4, 32'h0000_0002, 4'hF, 32'h0};
        vecs[2]  = '{1'b1, 4'h8, 32'h0000_0003, 4'hF, 32'h0};
        vecs[3]  = '{1'b1, 4'hC, 32'h0000_0004, 4'hF, 32'h0};
        vecs[4]  = '{1'b0, 4'h0, 32'h0,         4'h0, 32'h0000_0001};
        vecs[5]  = '{1'b0, 4'h4, 32'h0,         4'h0, 32'h0000_0002};
        vecs[6]  = '{1'b0, 4'h8, 32'h0,         4'h0, 32'h0000_0003};
        vecs[7]  = '{1'b0, 4'hC, 32'h0,         4'h0, 32'h0000_0004};
        vecs[8]  = '{1'b1, 4'h4, 32'hAABB_CCDD, 4'hF, 32'h0};
        vecs[9]  = '{1'b1, 4'h4, 32'h1122_3344, 4'h5, 32'h0};
        vecs[10] = '{1'b0, 4'h4, 32'h0,         4'h0, 32'hAA22_CC44};
        vecs[11] = '{1'b1, 4'hE, 32'hFFFF_FFFF, 4'h0, 32'h0};
        vecs[12] = '{1'b0, 4'hF, 32'h0,         4'h0, 32'h0000_0004};
        vecs[13] = '{1'b1, 4'h2, 32'h0000_00FF, 4'h1, 32'h0};
        vecs[14] = '{1'b0, 4'h1, 32'h0,         4'h0, 32'h0000_00FF};

        repeat (10) step();
        check("rst_reg_q", reg_q, 128'h0);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_rdata", rdata, 32'h0);
        check("rst_readies", {awready, wready, arready}, 3'b000);
        areset = 1'b0;
        #1;
        check("release_readies_before_clk", {awready, wready, arready}, 3'b000);
        step();
        check("release_readies", {awready, wready, arready}, 3'b111);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else               do_read(vecs[i].addr, vecs[i].exp);
        end

        // Channel ordering: AW leads W by two cycles, then W leads AW by three.
        write_split(4'h8, 32'hA5A5_A5A5, 1'b1, 2);
        write_split(4'h8, 32'h5A5A_5A5A, 1'b0, 3);
        check("order_reg2", reg_q[2], 32'h5A5A_5A5A);
        do_read(4'h8, 32'h5A5A_5A5A);

        // Backpressure on both response channels.
        bready = 1'b0; rready = 1'b0;
        model_write(4'h4, 32'h0BAD_F00D, 4'hF);
        bp_exp = model[2];
        rd_q.push_back(bp_exp);
        awaddr = 4'h4; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 4'h8;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        wdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 10; c++) begin
            check("bp_valids", {bvalid, rvalid}, 2'b11);
            check("bp_rdata", rdata, bp_exp);
            check("bp_readies", {awready, wready, arready}, 3'b000);
            step();
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("bp_no_second_commit", reg_q[1], 32'h0BAD_F00D);
        bready = 1'b1; rready = 1'b1;
        fork
            wait_b();
            wait_r();
        join

        // Simultaneous read and write of register 0 returns the old value.
        do_write(4'h0, 32'h7, 4'hF);
        model_write(4'h0, 32'h9, 4'hF);
        rd_q.push_back(32'h7);
        awaddr = 4'h0; wdata = 32'h9; wstrb = 4'hF; araddr = 4'h0;
        check("sim_readies", {awready, wready, arready}, 3'b111);
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        fork
            wait_b();
            wait_r();
        join
        do_read(4'h0, 32'h9);

        // Reset while the write address has been accepted but no data yet.
        awaddr = 4'h4; awvalid = 1'b1;
        step();
        awvalid = 1'b0;
        check("mid_have_aw", {awready, wready}, 2'b01);
        areset = 1'b1;
        #1;
        check("mid_rst_reg_q", reg_q, 128'h0);
        check("mid_rst_bvalid", bvalid, 1'b0);
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        repeat (3) step();
        areset = 1'b0;
        step();
        check("mid_release_readies", {awready, wready, arready}, 3'b111);
        repeat (4) step();
        check("mid_no_bvalid", bvalid, 1'b0);
        do_read(4'h0, 32'h0);

        step();
        check("rd_q_drained", rd_q.size(), 0);
        check("pulse_q_drained", pulse_q.size(), 0);
        check("b_all_seen", exp_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
